// File: rtl/voting_ack_sequencer.sv
// voting_ack_sequencer: round-robin arbiter that shares one CPU-driven ack pulse among vote-request lines.
// The Avalon-MM slave exposes the grant, the pulse length, the request mask and a completed-ack count.
module voting_ack_sequencer #(
    parameter int NUM_VOTERS    = 4,
    parameter int PULSE_W       = 16,
    parameter int DEFAULT_PULSE = 50
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [NUM_VOTERS-1:0] vote_req,
    output logic [NUM_VOTERS-1:0] ack_out,
    output logic                  irq
);
    typedef enum logic [1:0] {IDLE, PENDING, PULSE, HOLDOFF} state_t;
    state_t state, state_n;
    logic [NUM_VOTERS-1:0] req_m, req_s, mask;
    logic [PULSE_W-1:0] pulse_len, cnt;
    logic [15:0] count, elig16, req16;
    logic [3:0] idx, last_grant, gnt, j;
    logic found, wr, cmd_ack, cmd_cancel, done, unused_wd;
    logic [31:0] status;

    assign wr         = chipselect && !write_n;
    assign cmd_ack    = wr && address == 2'd0 && writedata[0];
    assign cmd_cancel = wr && address == 2'd0 && writedata[1];
    assign elig16     = 16'(req_s & mask);
    assign req16      = 16'(req_s);
    assign done       = state == PULSE && cnt == PULSE_W'(1);
    assign unused_wd  = ^writedata;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        found = 1'b0;
        gnt   = last_grant;
        j     = last_grant;
        for (int i = 0; i < NUM_VOTERS; i++) begin
            j = (j == 4'(NUM_VOTERS - 1)) ? 4'd0 : j + 4'd1;
            if (!found && elig16[j]) begin
                found = 1'b1;
                gnt   = j;
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? PENDING : IDLE;
            PENDING: state_n = cmd_ack ? PULSE : cmd_cancel ? IDLE : PENDING;
            PULSE:   state_n = done ? HOLDOFF : PULSE;
            HOLDOFF: state_n = req16[idx] ? HOLDOFF : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_m      <= '0;
            req_s      <= '0;
            mask       <= '1;
            pulse_len  <= PULSE_W'(DEFAULT_PULSE);
            cnt        <= '0;
            count      <= '0;
            idx        <= '0;
            last_grant <= 4'(NUM_VOTERS - 1);
        end else begin
            state <= state_n;
            req_m <= vote_req;
            req_s <= req_m;
            if (state == IDLE && found)
                idx <= gnt;
            if (state == PENDING && cmd_ack)
                cnt <= (pulse_len == '0) ? PULSE_W'(1) : pulse_len;
            else if (state == PULSE)
                cnt <= cnt - PULSE_W'(1);
            if ((state == PENDING && !cmd_ack && cmd_cancel) || done)
                last_grant <= idx;
            if (wr && address == 2'd1)
                pulse_len <= writedata[PULSE_W-1:0];
            if (wr && address == 2'd2)
                mask <= writedata[NUM_VOTERS-1:0];
            // A COUNT write takes priority over a completing pulse.
            if (wr && address == 2'd3)
                count <= '0;
            else if (done)
                count <= count + 16'd1;
        end
    end

    assign status   = {24'd0, (state != IDLE) ? idx : 4'd0, 2'd0,
                       state == PULSE || state == HOLDOFF, state == PENDING};
    assign readdata = address == 2'd0 ? status :
                      address == 2'd1 ? 32'(pulse_len) :
                      address == 2'd2 ? 32'(mask) : {16'd0, count};
    assign ack_out  = (state == PULSE) ? NUM_VOTERS'(1) << idx : '0;
    assign irq      = state == PENDING;
endmodule

// File: tb/tb_voting_ack_sequencer.sv
// tb_voting_ack_sequencer: register table plus directed multi-cycle sequences for the ack sequencer.
module tb_voting_ack_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  vote_req = '0;
    logic [3:0]  ack_out;
    logic        irq;
    int checks = 0;
    int errors = 0;

    voting_ack_sequencer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .vote_req(vote_req), .ack_out(ack_out), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_irq(input string name);
        int n = 0;
        while (!irq && n < 30) begin
            tick(1);
            n++;
        end
        chk(name, 32'(irq), 32'd1);
    endtask

    task automatic measure_pulse(output int n);
        n = 0;
        while (ack_out != 0 && n < 200) begin
            n++;
            tick(1);
        end
    endtask

    task automatic release_idle(input string name);
        logic [31:0] d;
        int n = 0;
        vote_req = '0;
        rd(2'd0, d);
        while (d != 0 && n < 30) begin
            tick(1);
            rd(2'd0, d);
            n++;
        end
        chk(name, d, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    initial begin
        vec_t vt[$];
        logic [31:0] d;
        int n;
        vt = '{
            '{"rst_status", 1'b0, 2'd0, 32'h0,        32'h0},
            '{"rst_plen",   1'b0, 2'd1, 32'h0,        32'd50},
            '{"rst_mask",   1'b0, 2'd2, 32'h0,        32'hF},
            '{"rst_count",  1'b0, 2'd3, 32'h0,        32'h0},
            '{"plen_trunc", 1'b1, 2'd1, 32'hFFFF1234, 32'h1234},
            '{"mask_a",     1'b1, 2'd2, 32'h0000000A, 32'hA},
            '{"mask_trunc", 1'b1, 2'd2, 32'hFFFFFFF5, 32'h5},
            '{"cmd_idle",   1'b1, 2'd0, 32'h00000001, 32'h0},
            '{"count_clr",  1'b1, 2'd3, 32'h00000055, 32'h0},
            '{"plen_back",  1'b1, 2'd1, 32'd50,       32'd50},
            '{"mask_back",  1'b1, 2'd2, 32'hF,        32'hF}
        };
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("rst_ack", 32'(ack_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        foreach (vt[i]) begin
            if (vt[i].we) wr_reg(vt[i].addr, vt[i].wd);
            rd(vt[i].addr, d);
            chk(vt[i].name, d, vt[i].exp);
        end

        // Single voter: 3-edge latency, 50-cycle pulse, then release.
        vote_req = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            chk($sformatf("lat_irq_%0d", k), 32'(irq), 32'(k == 3));
        end
        rd(2'd0, d);
        chk("pend_status", d, 32'h21);
        wr_reg(2'd0, 32'h1);
        chk("pulse_onehot", 32'(ack_out), 32'h4);
        rd(2'd0, d);
        chk("busy_status", d, 32'h22);
        measure_pulse(n);
        chk("pulse_len50", 32'(n), 32'd50);
        rd(2'd3, d);
        chk("count_one", d, 32'd1);
        rd(2'd0, d);
        chk("holdoff_status", d, 32'h22);
        release_idle("drop_idle");

        // Round-robin with release/reassert after each ack.
        do_reset();
        wr_reg(2'd1, 32'd2);
        vote_req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_irq($sformatf("rr_irq_%0d", i));
            rd(2'd0, d);
            chk($sformatf("rr_idx_%0d", i), 32'(d[7:4]), 32'(i % 4));
            wr_reg(2'd0, 32'h1);
            vote_req[i % 4] = 1'b0;
            wait_irq($sformatf("rr_next_%0d", i));
            vote_req[i % 4] = 1'b1;
        end
        rd(2'd3, d);
        chk("rr_count", d, 32'd5);
        vote_req = '0;
        tick(3);
        wr_reg(2'd0, 32'h2);
        release_idle("rr_idle");

        // Zero length means one cycle; mid-pulse length change only affects the next pulse.
        wr_reg(2'd1, 32'd0);
        vote_req = 4'b0001;
        wait_irq("p0_irq");
        wr_reg(2'd0, 32'h1);
        measure_pulse(n);
        chk("pulse_len0", 32'(n), 32'd1);
        release_idle("p0_idle");
        wr_reg(2'd1, 32'd10);
        vote_req = 4'b0001;
        wait_irq("p10_irq");
        wr_reg(2'd0, 32'h1);
        n = 1;
        wr_reg(2'd1, 32'd3);
        while (ack_out != 0 && n < 200) begin
            n++;
            tick(1);
        end
        chk("pulse_midwrite", 32'(n), 32'd10);
        release_idle("p10_idle");
        vote_req = 4'b0001;
        wait_irq("p3_irq");
        wr_reg(2'd0, 32'h1);
        measure_pulse(n);
        chk("pulse_len3", 32'(n), 32'd3);
        release_idle("p3_idle");
        rd(2'd3, d);
        chk("count_eight", d, 32'd8);

        // Masking, grant persistence, and cancel.
        wr_reg(2'd2, 32'hE);
        vote_req = 4'b0001;
        tick(6);
        chk("masked_irq", 32'(irq), 32'd0);
        vote_req = 4'b0011;
        wait_irq("mask_irq");
        rd(2'd0, d);
        chk("mask_grant1", d, 32'h11);
        vote_req = 4'b0000;
        tick(4);
        chk("persist_irq", 32'(irq), 32'd1);
        rd(2'd0, d);
        chk("persist_status", d, 32'h11);
        vote_req = 4'b0111;
        tick(3);
        wr_reg(2'd0, 32'h2);
        chk("cancel_ack", 32'(ack_out), 32'h0);
        chk("cancel_irq", 32'(irq), 32'd0);
        wait_irq("after_cancel_irq");
        rd(2'd0, d);
        chk("skip_to_2", d, 32'h21);
        rd(2'd3, d);
        chk("cancel_count", d, 32'd8);
        wr_reg(2'd2, 32'h0);
        tick(3);
        chk("mask_clr_persist", 32'(irq), 32'd1);
        vote_req = '0;
        tick(3);
        wr_reg(2'd0, 32'h2);
        release_idle("cancel_idle");
        wr_reg(2'd2, 32'hF);

        // Asynchronous reset mid-pulse.
        wr_reg(2'd1, 32'd20);
        vote_req = 4'b0001;
        wait_irq("ar_irq");
        wr_reg(2'd0, 32'h1);
        tick(3);
        chk("ar_pulsing", 32'(ack_out), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("ar_ack", 32'(ack_out), 32'h0);
        chk("ar_irq", 32'(irq), 32'd0);
        rd(2'd3, d);
        chk("ar_count", d, 32'd0);
        rd(2'd1, d);
        chk("ar_plen", d, 32'd50);
        tick(1);
        reset_n = 1'b1;

        // COUNT clear in the same cycle as completion, with ack+cancel both set.
        wr_reg(2'd1, 32'd2);
        wait_irq("cc_irq");
        wr_reg(2'd0, 32'h3);
        chk("both_ack_wins", 32'(ack_out), 32'h1);
        tick(1);
        wr_reg(2'd3, 32'h0);
        chk("cc_ack_done", 32'(ack_out), 32'h0);
        rd(2'd3, d);
        chk("cc_count", d, 32'd0);
        rd(2'd0, d);
        chk("cc_holdoff", d, 32'h02);
        release_idle("cc_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
